// File: rtl/demux_frame_ctrl_pkg.sv
// demux_frame_ctrl shared types and constants
// Frame: start, 2-bit address, payload, stop
package demux_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    STOP
  } state_t;

  localparam int   NUM_CH     = 4;
  localparam int   SEL_W      = $clog2(NUM_CH);
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/demux_frame_ctrl_if.sv
// demux_frame_ctrl serial-in / demux-side bundle
// master drives the line, slave is the receiver
interface demux_frame_ctrl_if;
  import demux_frame_ctrl_pkg::*;

  logic             din;
  logic             en;
  logic [SEL_W-1:0] sel;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_done;
  logic             frame_err;

  modport master (
    output din, en,
    input  sel, dout, dout_valid,
    input  busy, frame_done, frame_err
  );

  modport slave (
    input  din, en,
    output sel, dout, dout_valid,
    output busy, frame_done, frame_err
  );

endinterface

// File: rtl/demux_frame_ctrl.sv
// demux_frame_ctrl: serial frame receiver
// feeding select and data of a 1-to-4 demux
module demux_frame_ctrl
  import demux_frame_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_frame_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_BITS - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_addr_cnt;
  logic             r_addr_msb;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_done;
  logic             r_err;
  logic             w_start;

  assign w_start = (bus.din != IDLE_LEVEL);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next state, only advances on sample strobe
  always_comb begin
    w_next = r_state;
    if (bus.en) begin
      unique case (r_state)
        IDLE: if (w_start) w_next = ADDR;
        ADDR: if (r_addr_cnt) w_next = DATA;
        DATA: if (r_bit_cnt == LAST)
                w_next = STOP;
        STOP: w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // counters, select and one-cycle outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_cnt   <= 1'b0;
      r_addr_msb   <= 1'b0;
      r_bit_cnt    <= '0;
      r_sel        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      if (bus.en) begin
        unique case (r_state)
          IDLE: if (w_start) r_addr_cnt <= 1'b0;
          ADDR: begin
            if (!r_addr_cnt) begin
              r_addr_msb <= bus.din;
              r_addr_cnt <= 1'b1;
            end else begin
              r_sel      <= {r_addr_msb, bus.din};
              r_addr_cnt <= 1'b0;
              r_bit_cnt  <= '0;
            end
          end
          DATA: begin
            r_dout       <= bus.din;
            r_dout_valid <= 1'b1;
            r_bit_cnt    <= r_bit_cnt + 1'b1;
          end
          STOP: begin
            r_done <= bus.din;
            r_err  <= ~bus.din;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sel        = r_sel;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;

endmodule

// File: tb/tb_demux_frame_ctrl.sv
// tb_demux_frame_ctrl: directed frames
// with hand-derived expected outputs
module tb_demux_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid  = 0;
  int   n_done   = 0;
  logic [1:0] exp_sel = 2'd0;

  demux_frame_ctrl_if bus ();

  demux_frame_ctrl #(.DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  // one strobed sample, ends 1ns after edge
  task automatic sample(input logic b);
    bus.en  = 1'b1;
    bus.din = b;
    @(posedge clk);
    #1;
    bus.en  = 1'b0;
    bus.din = 1'b1;
    if (bus.dout_valid) n_valid++;
    if (bus.frame_done) n_done++;
  endtask

  // en=0 cycles: pulses low, state held
  task automatic idle(input int n,
                      input logic bsy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.dout_valid) n_valid++;
      check("gap_valid", bus.dout_valid, 0);
      check("gap_dout", bus.dout, 0);
      check("gap_done", bus.frame_done, 0);
      check("gap_err", bus.frame_err, 0);
      check("gap_busy", bus.busy, bsy);
      check("gap_sel", bus.sel, exp_sel);
    end
  endtask

  task automatic send_frame(input logic [1:0] a,
                            input logic [7:0] d,
                            input logic stp,
                            input int gap);
    sample(1'b0);
    check("start_busy", bus.busy, 1);
    check("start_sel", bus.sel, exp_sel);
    check("start_valid", bus.dout_valid, 0);
    idle(gap, 1'b1);
    sample(a[1]);
    check("a1_sel", bus.sel, exp_sel);
    idle(gap, 1'b1);
    sample(a[0]);
    exp_sel = a;
    check("a0_sel", bus.sel, a);
    check("a0_valid", bus.dout_valid, 0);
    idle(gap, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      sample(d[i]);
      check("d_valid", bus.dout_valid, 1);
      check("d_bit", bus.dout, d[i]);
      check("d_sel", bus.sel, a);
      idle(gap, 1'b1);
    end
    sample(stp);
    check("stop_done", bus.frame_done, stp);
    check("stop_err", bus.frame_err, !stp);
    check("stop_busy", bus.busy, 0);
    check("stop_valid", bus.dout_valid, 0);
    check("stop_dout", bus.dout, 0);
    check("stop_sel", bus.sel, a);
    idle(gap, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", bus.sel, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_err", bus.frame_err, 0);
    rst = 1'b0;
    exp_sel = 2'd0;
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.din = 1'b1;
    do_reset();

    // 1: addr 2, A5, good stop
    n_valid = 0;
    n_done  = 0;
    send_frame(2'd2, 8'hA5, 1'b1, 0);
    check("t1_nvalid", n_valid, 8);
    check("t1_ndone", n_done, 1);

    // 2: bad stop, sel kept afterwards
    n_done = 0;
    send_frame(2'd2, 8'hA5, 1'b0, 0);
    check("t2_ndone", n_done, 0);
    idle(2, 1'b0);
    check("t2_sel", bus.sel, 2);

    // 3: en every 3rd cycle
    n_valid = 0;
    send_frame(2'd3, 8'hFF, 1'b1, 2);
    check("t3_nvalid", n_valid, 8);
    check("t3_sel", bus.sel, 3);

    // 4: async reset after 4th data bit
    sample(1'b0);
    sample(1'b0);
    sample(1'b1);
    for (int i = 0; i < 4; i++) sample(1'b1);
    check("t4_pre_valid", bus.dout_valid, 1);
    check("t4_pre_sel", bus.sel, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_sel", bus.sel, 0);
    check("t4_dout", bus.dout, 0);
    check("t4_valid", bus.dout_valid, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_done", bus.frame_done, 0);
    check("t4_err", bus.frame_err, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_sel = 2'd0;
    @(posedge clk);
    #1;
    check("t4_post_done", bus.frame_done, 0);
    check("t4_post_err", bus.frame_err, 0);
    n_done = 0;
    send_frame(2'd0, 8'h01, 1'b1, 0);
    check("t4_ndone", n_done, 1);

    // 5: back-to-back frames
    n_done  = 0;
    n_valid = 0;
    send_frame(2'd1, 8'h0F, 1'b1, 0);
    send_frame(2'd3, 8'hF0, 1'b1, 0);
    check("t5_ndone", n_done, 2);
    check("t5_nvalid", n_valid, 16);

    // 6: idle line after reset
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 50; i++) begin
      sample(1'b1);
      check("t6_busy", bus.busy, 0);
      check("t6_valid", bus.dout_valid, 0);
    end
    check("t6_nvalid", n_valid, 0);
    check("t6_sel", bus.sel, 0);

    $display("CHECKS %0d ERRORS %0d",
             n_checks, n_errors);
    $finish;
  end

endmodule
